mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised memory-stage unit for the von-Neumann mini-RISC16 pipeline, placed between ALU and writeback. It owns the single shared RAM port whenever a load or store executes, stalls IF/ID/ALU for multi-cycle loads, and substitutes a NOP word into the IF data path for every fetch slot it steals. It generalises the previous single-cycle, load-only memory stage with configurable read latency, stores, and an in-flight valid tag.

## Interface
- DATA_WIDTH, 16, RAM word and data-bus width
- ADDR_WIDTH, 16, address width carried on the control bus
- RAM_ADDR_WIDTH, 16, RAM address width; ram_addr = mem_addr[RAM_ADDR_WIDTH-1:0]
- CBUS_WIDTH, 32, pass-through control bus width
- RD_LATENCY, 1, cycles from address to valid ram_rdata; legal 1..8
- NOP_WORD, 16'h0000, instruction word injected into IF on a stolen slot
- gclk  in  1  clock, rising edge
- grst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  stage input holds a live instruction
- in_cbus  in  CBUS_WIDTH  control bus from ALU stage
- mem_en / mem_we  in  1 / 1  memory op requested / 1 = store, 0 = load
- mem_addr  in  ADDR_WIDTH  effective address
- in_data  in  DATA_WIDTH  ALU result (non-load writeback value)
- store_data  in  DATA_WIDTH  store payload
- stall  out  1  freeze IF/ID/ALU
- out_valid / out_cbus / out_data  out  1 / CBUS_WIDTH / DATA_WIDTH  registered writeback bus
- ram_addr_sel  out  1  1 = MEM drives RAM address, 0 = IF
- ram_addr  out  RAM_ADDR_WIDTH  MEM-side RAM address
- ram_we / ram_wdata  out  1 / DATA_WIDTH  RAM write strobe and data
- ram_rdata  in  DATA_WIDTH  RAM read data
- if_data_sel  out  1  1 = IF takes if_bypass_data instead of ram_rdata
- if_bypass_data  out  DATA_WIDTH  constant NOP_WORD

## Operation
- States: IDLE, RD_WAIT, RD_DONE. Down-counter cnt, width clog2(RD_LATENCY+1).
- IDLE, in_valid & mem_en & !mem_we (load): ram_addr_sel=1, ram_addr=mem_addr, stall=1; cnt<=RD_LATENCY-1; next RD_DONE if RD_LATENCY==1 else RD_WAIT. Address latched in addr_q.
- RD_WAIT: ram_addr_sel=1, ram_addr=addr_q, stall=1; cnt decrements; at cnt==1 next RD_DONE.
- RD_DONE: ram_addr_sel=1, ram_addr=addr_q, stall=0; out_data<=ram_rdata, out_cbus<=in_cbus, out_valid<=1; next IDLE. Held input load is consumed at this edge and must not re-trigger.
- IDLE, in_valid & mem_en & mem_we (store): ram_we=1, ram_addr_sel=1, ram_wdata=store_data, stall=0; out_data<=in_data, out_valid<=1. Stays IDLE.
- IDLE otherwise: ram_addr_sel=0, ram_we=0, stall=0; out_* <= in_valid/in_cbus/in_data.
- While stall=1: out_valid<=0 (bubble), out_cbus/out_data hold.
- if_data_sel = ram_addr_sel delayed exactly RD_LATENCY cycles (shift register), so each IF fetch slot whose address was displaced returns NOP_WORD.
- ram_we is asserted only in IDLE on a store; never during a load sequence.

## Timing
- Load: stall high RD_LATENCY cycles, port held RD_LATENCY+1 cycles, out_valid for the load 1 cycle after RD_DONE edge; total latency RD_LATENCY+1.
- Store: 0 stall cycles, one port cycle, one IF NOP slot RD_LATENCY cycles later.
- Back-to-back memory ops: second op is evaluated in the IDLE cycle following RD_DONE; no gap beyond that.
- Reset values: state IDLE, cnt 0, delay line 0, stall 0, out_valid 0, out_cbus 0, out_data 0, ram_addr_sel 0, ram_we 0, if_data_sel 0. Reset mid-load aborts with no writeback and no write strobe.
- mem_en with in_valid=0 is ignored.
- All outputs except out_* and if_data_sel are combinational from state and inputs.

## Structure
- Shared core header package: DATA/ADDR widths, CBUS slice positions for MEM enable/load-store/address, MEM_LOAD/MEM_STORE encodings, NOP_WORD, state encoding.
- One sub-module: mem_sel_delay (parametrised 1-bit shift register of depth RD_LATENCY, async active-low clear) producing if_data_sel.

## Test plan
- RD_LATENCY=1, load addr 0x0010, RAM[0x10]=0xBEEF -> stall 1 cycle, ram_addr_sel 2 cycles, out_data=0xBEEF with out_valid 1, if_data_sel high the 2 cycles after ram_addr_sel.
- RD_LATENCY=3, load addr 0x0042 -> stall exactly 3 cycles, out_valid=0 during stall, out_data=RAM[0x42] after 4th edge.
- Store 0x1234 to 0x0020 then load 0x0020 -> ram_we one cycle, no stall on store, load returns 0x1234.
- Alternating load/store/load stream, RD_LATENCY=2 -> every instruction appears once on out_valid, order preserved, IF slot count displaced equals if_data_sel pulses.
- grst_n low during RD_WAIT -> all outputs reset values immediately, no writeback of aborted load, next load after release behaves normally.
- in_valid=0 with mem_en=1 -> no stall, ram_addr_sel 0, out_valid 0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared core header for the mini-RISC16 memory stage: widths, control-bus
// field positions, memory-op encodings and the memory-stage state encoding.
package mem_access_unit_pkg;

  localparam int MAU_DATA_W = 16;
  localparam int MAU_ADDR_W = 16;
  localparam int MAU_CBUS_W = 32;

  // Control-bus slices consumed by the memory stage
  localparam int CBUS_MEM_EN_BIT  = 0;
  localparam int CBUS_MEM_WE_BIT  = 1;
  localparam int CBUS_MEM_ADR_LSB = 2;
  localparam int CBUS_MEM_ADR_MSB = CBUS_MEM_ADR_LSB + MAU_ADDR_W - 1;

  localparam logic [MAU_DATA_W-1:0] NOP_WORD_DEF = 16'h0000;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_DONE = 2'd2
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_sel_delay.sv
// 1-bit delay line: replays the RAM-port steal signal RD_LATENCY cycles later,
// which is when the displaced IF fetch would have returned its data.
module mem_sel_delay #(
  parameter int DEPTH = 1
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sel_pipe_q;

  // Shift in at bit 0; the concat is one bit wider and the cast drops the oldest
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) sel_pipe_q <= '0;
    else         sel_pipe_q <= DEPTH'({sel_pipe_q, din});
  end

  assign dout = sel_pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage between ALU and writeback. Takes the shared RAM port for loads
// and stores, stalls the front end while a load is outstanding, and flags the
// IF fetch slots it stole so IF consumes a NOP instead of stale RAM data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH     = MAU_DATA_W,
  parameter int                    ADDR_WIDTH     = MAU_ADDR_W,
  parameter int                    RAM_ADDR_WIDTH = 16,
  parameter int                    CBUS_WIDTH     = MAU_CBUS_W,
  parameter int                    RD_LATENCY     = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD       = DATA_WIDTH'(NOP_WORD_DEF)
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  logic                      in_valid,
  input  logic [CBUS_WIDTH-1:0]     in_cbus,
  input  logic                      mem_en,
  input  logic                      mem_we,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [DATA_WIDTH-1:0]     store_data,
  output logic                      stall,
  output logic                      out_valid,
  output logic [CBUS_WIDTH-1:0]     out_cbus,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      ram_addr_sel,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_we,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata,
  output logic                      if_data_sel,
  output logic [DATA_WIDTH-1:0]     if_bypass_data
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  mau_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      out_valid_q, out_valid_d;
  logic [CBUS_WIDTH-1:0]     out_cbus_q, out_cbus_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic                      mem_req;

  assign mem_req = in_valid & mem_en;

  // Next-state, writeback bus and combinational RAM-port control
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    out_valid_d  = 1'b0;
    out_cbus_d   = out_cbus_q;
    out_data_d   = out_data_q;
    stall        = 1'b0;
    ram_addr_sel = 1'b0;
    ram_addr     = mem_addr[RAM_ADDR_WIDTH-1:0];
    ram_we       = 1'b0;
    ram_wdata    = store_data;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req && mem_we == MEM_LOAD) begin
          // Issue the read now; front end frozen until data is back
          ram_addr_sel = 1'b1;
          stall        = 1'b1;
          addr_d       = mem_addr[RAM_ADDR_WIDTH-1:0];
          cnt_d        = CNT_W'(RD_LATENCY - 1);
          state_d      = (RD_LATENCY == 1) ? ST_RD_DONE : ST_RD_WAIT;
        end else if (mem_req && mem_we == MEM_STORE) begin
          // Stores complete in one port cycle, no stall
          ram_addr_sel = 1'b1;
          ram_we       = 1'b1;
          out_valid_d  = 1'b1;
          out_cbus_d   = in_cbus;
          out_data_d   = in_data;
        end else begin
          out_valid_d  = in_valid;
          out_cbus_d   = in_cbus;
          out_data_d   = in_data;
        end
      end
      ST_RD_WAIT: begin
        ram_addr_sel = 1'b1;
        ram_addr     = addr_q;
        stall        = 1'b1;
        cnt_d        = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RD_DONE;
      end
      ST_RD_DONE: begin
        // Data valid this cycle; releasing stall lets the held load retire
        ram_addr_sel = 1'b1;
        ram_addr     = addr_q;
        out_valid_d  = 1'b1;
        out_cbus_d   = in_cbus;
        out_data_d   = ram_rdata;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, read counter, latched address and registered writeback bus
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_cbus_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_cbus_q  <= out_cbus_d;
      out_data_q  <= out_data_d;
    end
  end

  mem_sel_delay #(.DEPTH(RD_LATENCY)) u_sel_delay (
    .gclk   (gclk),
    .grst_n (grst_n),
    .din    (ram_addr_sel),
    .dout   (if_data_sel)
  );

  assign out_valid      = out_valid_q;
  assign out_cbus       = out_cbus_q;
  assign out_data       = out_data_q;
  assign if_bypass_data = NOP_WORD;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: three memory-stage instances at read latencies 1, 2 and 3,
// each with its own latency-accurate RAM model.
module tb_mem_access_unit;

  localparam int NI = 3;

  logic        gclk = 1'b0;
  logic        grst_n = 1'b0;
  logic        mem_clr = 1'b1;
  logic        mon_en = 1'b0;

  logic        in_valid   [NI];
  logic [31:0] in_cbus    [NI];
  logic        mem_en     [NI];
  logic        mem_we     [NI];
  logic [15:0] mem_addr   [NI];
  logic [15:0] in_data    [NI];
  logic [15:0] store_data [NI];
  logic        stall      [NI];
  logic        out_valid  [NI];
  logic [31:0] out_cbus   [NI];
  logic [15:0] out_data   [NI];
  logic        sel        [NI];
  logic [15:0] ram_addr   [NI];
  logic        ram_we     [NI];
  logic [15:0] ram_wdata  [NI];
  logic [15:0] ram_rdata  [NI];
  logic        if_sel     [NI];
  logic [15:0] if_byp     [NI];

  int n_chk = 0;
  int n_pass = 0;

  always #5 gclk = ~gclk;

  function automatic logic [15:0] init_word(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hBEEF;
      8'h30:   return 16'hC0DE;
      8'h42:   return 16'h5A42;
      default: return {8'hA0, a};
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_access_unit #(.RD_LATENCY(g + 1)) u_dut (
      .gclk           (gclk),
      .grst_n         (grst_n),
      .in_valid       (in_valid[g]),
      .in_cbus        (in_cbus[g]),
      .mem_en         (mem_en[g]),
      .mem_we         (mem_we[g]),
      .mem_addr       (mem_addr[g]),
      .in_data        (in_data[g]),
      .store_data     (store_data[g]),
      .stall          (stall[g]),
      .out_valid      (out_valid[g]),
      .out_cbus       (out_cbus[g]),
      .out_data       (out_data[g]),
      .ram_addr_sel   (sel[g]),
      .ram_addr       (ram_addr[g]),
      .ram_we         (ram_we[g]),
      .ram_wdata      (ram_wdata[g]),
      .ram_rdata      (ram_rdata[g]),
      .if_data_sel    (if_sel[g]),
      .if_bypass_data (if_byp[g])
    );

    // RAM: read data appears g+1 (= RD_LATENCY) cycles after the address
    logic [7:0]   ad_dly [g+1];
    logic [255:0] wv;
    logic [15:0]  wm [256];
    int           sel_cnt, ifs_cnt;

    always @(posedge gclk) begin
      ad_dly[0] <= ram_addr[g][7:0];
      for (int k = 1; k <= g; k++) ad_dly[k] <= ad_dly[k-1];
    end

    always @(posedge gclk) begin
      if (mem_clr) wv <= '0;
      else if (ram_we[g]) begin
        wv[ram_addr[g][7:0]] <= 1'b1;
        wm[ram_addr[g][7:0]] <= ram_wdata[g];
      end
    end

    assign ram_rdata[g] = wv[ad_dly[g]] ? wm[ad_dly[g]] : init_word(ad_dly[g]);

    always @(negedge gclk) begin
      if (!mon_en) begin
        sel_cnt <= 0;
        ifs_cnt <= 0;
      end else begin
        sel_cnt <= sel_cnt + int'(sel[g]);
        ifs_cnt <= ifs_cnt + int'(if_sel[g]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic drive(input int i, input logic v, input logic en, input logic we,
                       input logic [15:0] a, input logic [31:0] cb,
                       input logic [15:0] d, input logic [15:0] sd);
    in_valid[i] = v;  mem_en[i] = en; mem_we[i] = we;
    mem_addr[i] = a;  in_cbus[i] = cb; in_data[i] = d; store_data[i] = sd;
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
    @(posedge gclk); #1;
  endtask

  // Load with inputs held through the stall; checks bubbles, stall length, result
  task automatic do_load(input int i, input logic [15:0] a, input logic [31:0] cb,
                         input logic [15:0] exp, input int exp_stall);
    int  ns = 0;
    bit  done = 0;
    drive(i, 1'b1, 1'b1, 1'b0, a, cb, 16'hFFFF, 16'h0);
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge gclk);
      chk("ld_sel", sel[i], 1);
      chk("ld_addr", ram_addr[i], a);
      chk("ld_we", ram_we[i], 0);
      if (!stall[i]) done = 1;
      else begin
        ns++;
        @(posedge gclk); #1;
        chk("ld_bubble", out_valid[i], 0);
      end
    end
    chk("ld_stall_cycles", ns, exp_stall);
    @(posedge gclk); #1;
    chk("ld_valid", out_valid[i], 1);
    chk("ld_data", out_data[i], exp);
    chk("ld_cbus", out_cbus[i], cb);
    drive(i, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
  endtask

  task automatic do_store(input int i, input logic [15:0] a, input logic [15:0] sd,
                          input logic [31:0] cb, input logic [15:0] wb);
    drive(i, 1'b1, 1'b1, 1'b1, a, cb, wb, sd);
    @(negedge gclk);
    chk("st_stall", stall[i], 0);
    chk("st_we", ram_we[i], 1);
    chk("st_sel", sel[i], 1);
    chk("st_addr", ram_addr[i], a);
    chk("st_wdata", ram_wdata[i], sd);
    @(posedge gclk); #1;
    chk("st_valid", out_valid[i], 1);
    chk("st_data", out_data[i], wb);
    chk("st_cbus", out_cbus[i], cb);
    drive(i, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
  endtask

  task automatic do_alu(input int i, input logic [31:0] cb, input logic [15:0] d);
    drive(i, 1'b1, 1'b0, 1'b0, 16'h0, cb, d, 16'h0);
    @(negedge gclk);
    chk("alu_stall", stall[i], 0);
    chk("alu_sel", sel[i], 0);
    chk("alu_we", ram_we[i], 0);
    @(posedge gclk); #1;
    chk("alu_valid", out_valid[i], 1);
    chk("alu_data", out_data[i], d);
    chk("alu_cbus", out_cbus[i], cb);
    drive(i, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) drive(i, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
    repeat (3) @(posedge gclk);
    #1;
    // Reset state, checked while reset is still asserted
    for (int i = 0; i < NI; i++) begin
      chk("rst_stall", stall[i], 0);
      chk("rst_valid", out_valid[i], 0);
      chk("rst_data", out_data[i], 0);
      chk("rst_cbus", out_cbus[i], 0);
      chk("rst_sel", sel[i], 0);
      chk("rst_we", ram_we[i], 0);
      chk("rst_ifsel", if_sel[i], 0);
      chk("nop_word", if_byp[i], 16'h0000);
    end
    grst_n  = 1'b1;
    mem_clr = 1'b0;
    @(posedge gclk); #1;

    // Latency 1 load: 1 stall, port 2 cycles, if_data_sel the 2 cycles after
    mon_en = 1'b1;
    do_load(0, 16'h0010, 32'h1111_0001, 16'hBEEF, 1);
    chk("l1_ifsel_hi", if_sel[0], 1);
    idle(0);
    chk("l1_ifsel_lo", if_sel[0], 0);
    idle(0);
    chk("l1_sel_cnt", g_dut[0].sel_cnt, 2);
    chk("l1_ifs_cnt", g_dut[0].ifs_cnt, 2);
    mon_en = 1'b0;
    idle(0);

    // Latency 3 load
    do_load(2, 16'h0042, 32'h3333_0042, 16'h5A42, 3);
    idle(2);

    // Store then back-to-back load of the same word
    do_store(0, 16'h0020, 16'h1234, 32'h2222_0020, 16'h00AA);
    do_load(0, 16'h0020, 32'h2222_0021, 16'h1234, 1);
    idle(0);

    // Latency 2 mixed stream; stolen slots must equal NOP slots
    mon_en = 1'b1;
    do_load (1, 16'h0030, 32'h4444_0001, 16'hC0DE, 2);
    do_store(1, 16'h0031, 16'h5555, 32'h4444_0002, 16'h0101);
    do_alu  (1, 32'h4444_0003, 16'h7777);
    do_load (1, 16'h0031, 32'h4444_0004, 16'h5555, 2);
    idle(1); idle(1); idle(1);
    chk("l2_sel_cnt", g_dut[1].sel_cnt, 7);
    chk("l2_ifs_cnt", g_dut[1].ifs_cnt, 7);
    mon_en = 1'b0;
    idle(1);

    // Reset in the middle of a latency-3 load
    drive(2, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h5555_0001, 16'h0, 16'h0);
    @(posedge gclk); #1;
    chk("ab_stall_pre", stall[2], 1);
    grst_n = 1'b0;
    drive(2, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 16'h0, 16'h0);
    #1;
    chk("ab_stall", stall[2], 0);
    chk("ab_sel", sel[2], 0);
    chk("ab_we", ram_we[2], 0);
    chk("ab_valid", out_valid[2], 0);
    chk("ab_data", out_data[2], 0);
    chk("ab_cbus", out_cbus[2], 0);
    chk("ab_ifsel", if_sel[2], 0);
    @(posedge gclk); #1;
    grst_n = 1'b1;
    @(posedge gclk); #1;
    chk("ab_no_wb", out_valid[2], 0);
    chk("ab_no_stall", stall[2], 0);
    do_load(2, 16'h0010, 32'h5555_0002, 16'hBEEF, 3);
    idle(2);

    // mem_en without in_valid is ignored
    drive(0, 1'b0, 1'b1, 1'b0, 16'h0010, 32'h6666_0001, 16'h0, 16'h0);
    @(negedge gclk);
    chk("nv_stall", stall[0], 0);
    chk("nv_sel", sel[0], 0);
    @(posedge gclk); #1;
    chk("nv_valid", out_valid[0], 0);
    idle(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
